// File: rtl/divisor_radix_hs.sv
// Iterative restoring divider: BITS_PER_CYCLE quotient bits per clock, signed/unsigned per
// operation, Busy/Done handshake and divide-by-zero reporting.
module divisor_radix_hs #(
    parameter int tamanyo        = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic               Signed,
    input  logic [tamanyo-1:0] Num,
    input  logic [tamanyo-1:0] Den,
    output logic [tamanyo-1:0] Coc,
    output logic [tamanyo-1:0] Res,
    output logic               Busy,
    output logic               Done,
    output logic               DivZero
);
    localparam int W  = tamanyo;
    localparam int N  = tamanyo / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CONT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   m_q, m_d;
    logic [W:0]     acc_q, acc_d;
    logic [CW-1:0]  cont_q, cont_d;
    logic           sign_num_q, sign_num_d;
    logic           sign_den_q, sign_den_d;
    logic [W-1:0]   coc_q, coc_d;
    logic [W-1:0]   res_q, res_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           divzero_q, divzero_d;

    logic           sign_num, sign_den, den_zero;
    logic [W-1:0]   num_mag, den_mag;
    logic [W:0]     acc_v, shifted;
    logic [W-1:0]   q_v;

    assign sign_num = Signed & Num[W-1];
    assign sign_den = Signed & Den[W-1];
    assign den_zero = (Den == '0);
    assign num_mag  = sign_num ? -Num : Num;
    assign den_mag  = sign_den ? -Den : Den;

    // ACCU stays below M after every step, so its top bit is zero before each shift.
    always_comb begin
        acc_v   = acc_q;
        q_v     = q_q;
        shifted = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {acc_v[W-1:0], q_v[W-1]};
            q_v     = {q_v[W-2:0], 1'b0};
            if (shifted >= {1'b0, m_q}) begin
                acc_v  = shifted - {1'b0, m_q};
                q_v[0] = 1'b1;
            end else begin
                acc_v = shifted;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Start) state_d = den_zero ? S_FIX : S_RUN;
            S_RUN:  if (cont_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // On divide-by-zero Q carries the raw dividend and M stays zero, marking the case in FIX.
    always_comb begin
        q_d        = q_q;
        m_d        = m_q;
        acc_d      = acc_q;
        cont_d     = cont_q;
        sign_num_d = sign_num_q;
        sign_den_d = sign_den_q;
        coc_d      = coc_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = done_q;
        divzero_d  = divzero_q;
        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (Start) begin
                    sign_num_d = sign_num;
                    sign_den_d = sign_den;
                    acc_d      = '0;
                    cont_d     = CONT_INIT;
                    busy_d     = 1'b1;
                    if (den_zero) begin
                        q_d = Num;
                        m_d = '0;
                    end else begin
                        q_d = num_mag;
                        m_d = den_mag;
                    end
                end
            end
            S_RUN: begin
                q_d    = q_v;
                acc_d  = acc_v;
                cont_d = cont_q - CW'(1);
            end
            S_FIX: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (m_q == '0) begin
                    coc_d     = '1;
                    res_d     = q_q;
                    divzero_d = 1'b1;
                end else begin
                    coc_d     = (sign_num_q ^ sign_den_q) ? -q_q : q_q;
                    res_d     = sign_num_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                    divzero_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            cont_q     <= '0;
            sign_num_q <= 1'b0;
            sign_den_q <= 1'b0;
            coc_q      <= '0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            divzero_q  <= 1'b0;
        end else begin
            q_q        <= q_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            cont_q     <= cont_d;
            sign_num_q <= sign_num_d;
            sign_den_q <= sign_den_d;
            coc_q      <= coc_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            divzero_q  <= divzero_d;
        end
    end

    always_comb begin
        Coc     = coc_q;
        Res     = res_q;
        Busy    = busy_q;
        Done    = done_q;
        DivZero = divzero_q;
    end

endmodule

// File: tb/tb_divisor_radix_hs.sv
// Bench for divisor_radix_hs: three instances (1, 2, 4 bits/cycle) share stimulus; a queue of
// reference results is consumed independently by each instance as its Done pulses arrive.
module tb_divisor_radix_hs;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic         dz;
        int           start_cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST, Start, Signed;
    logic [W-1:0] Num, Den;
    logic [W-1:0] coc_w [3];
    logic [W-1:0] res_w [3];
    logic         busy_w [3];
    logic         done_w [3];
    logic         dz_w [3];

    exp_t exp_q[$];
    int   rd_idx [3];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int BPC = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        divisor_radix_hs #(.tamanyo(W), .BITS_PER_CYCLE(BPC)) u_dut (
            .CLK(CLK), .RST(RST), .Start(Start), .Signed(Signed), .Num(Num), .Den(Den),
            .Coc(coc_w[gi]), .Res(res_w[gi]), .Busy(busy_w[gi]), .Done(done_w[gi]),
            .DivZero(dz_w[gi])
        );
    end

    function automatic int bpc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic exp_t model(input logic [W-1:0] num, input logic [W-1:0] den,
                                   input logic sgn);
        exp_t   e;
        longint n, d, q, r;
        e.start_cyc = 0;
        if (den == '0) begin
            e.coc = '1;
            e.res = num;
            e.dz  = 1'b1;
        end else begin
            if (sgn) begin
                n = longint'($signed(num));
                d = longint'($signed(den));
            end else begin
                n = longint'({32'b0, num});
                d = longint'({32'b0, den});
            end
            q     = n / d;
            r     = n % d;
            e.coc = q[W-1:0];
            e.res = r[W-1:0];
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    // Advance one clock and consume any Done pulses against the expected queue.
    task automatic tick();
        exp_t e;
        int   lat, exp_lat;
        @(posedge CLK);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                rd_idx[k] = exp_q.size();
            end else if (done_w[k] === 1'b1) begin
                checks++;
                if (rd_idx[k] >= exp_q.size()) begin
                    errors++;
                    $display("FAIL unexpected_done bpc=%0d got Done=1 required Done=0 cyc=%0d",
                             bpc_of(k), cyc);
                end else begin
                    e = exp_q[rd_idx[k]];
                    rd_idx[k]++;
                    lat     = cyc - e.start_cyc;
                    exp_lat = e.dz ? 1 : (W / bpc_of(k)) + 1;
                    checks += 4;
                    if (coc_w[k] !== e.coc) begin
                        errors++;
                        $display("FAIL coc bpc=%0d got %h required %h", bpc_of(k), coc_w[k], e.coc);
                    end
                    if (res_w[k] !== e.res) begin
                        errors++;
                        $display("FAIL res bpc=%0d got %h required %h", bpc_of(k), res_w[k], e.res);
                    end
                    if (dz_w[k] !== e.dz || busy_w[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL flags bpc=%0d got dz=%b busy=%b required dz=%b busy=0",
                                 bpc_of(k), dz_w[k], busy_w[k], e.dz);
                    end
                    if (lat != exp_lat) begin
                        errors++;
                        $display("FAIL latency bpc=%0d got %0d required %0d", bpc_of(k), lat, exp_lat);
                    end
                    $display("op bpc=%0d coc=%h res=%h dz=%b lat=%0d", bpc_of(k), coc_w[k],
                             res_w[k], dz_w[k], lat);
                end
            end
        end
    endtask

    task automatic start_op(input logic [W-1:0] num, input logic [W-1:0] den, input logic sgn);
        exp_t e;
        e      = model(num, den, sgn);
        Num    = num;
        Den    = den;
        Signed = sgn;
        Start  = 1'b1;
        tick();
        Start       = 1'b0;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start bpc=%0d got %b required 1", bpc_of(k), busy_w[k]);
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((rd_idx[0] < exp_q.size() || rd_idx[1] < exp_q.size() ||
                rd_idx[2] < exp_q.size()) && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL timeout got pending=%0d/%0d/%0d required 0", exp_q.size() - rd_idx[0],
                     exp_q.size() - rd_idx[1], exp_q.size() - rd_idx[2]);
            for (int k = 0; k < 3; k++) rd_idx[k] = exp_q.size();
        end
        tick();
    endtask

    task automatic run_op(input logic [W-1:0] num, input logic [W-1:0] den, input logic sgn);
        start_op(num, den, sgn);
        drain();
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({coc_w[k], res_w[k], busy_w[k], done_w[k], dz_w[k]} !== '0) begin
                errors++;
                $display("FAIL %s bpc=%0d got coc=%h res=%h busy=%b done=%b dz=%b required all 0",
                         tag, bpc_of(k), coc_w[k], res_w[k], busy_w[k], done_w[k], dz_w[k]);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Signed = 1'b0; Num = '0; Den = '0;
        tick();
        tick();
        check_zero_outputs("reset_state");
        RST = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op(32'h1234_5678, 32'd1, 1'b0);
        run_op(32'd0, 32'd9, 1'b0);
        run_op(32'd5, 32'd77, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_signed();
        run_op(-32'sd100, 32'sd7, 1'b1);
        run_op(32'sd100, -32'sd7, 1'b1);
        run_op(-32'sd100, -32'sd7, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'd1, 1'b1);
    endtask

    task automatic test_div_zero();
        run_op(32'h1234, 32'd0, 1'b0);
        run_op(32'h1234, 32'd0, 1'b1);
        run_op(32'h8000_0001, 32'd0, 1'b1);
    endtask

    task automatic test_start_ignored();
        start_op(32'hDEAD_BEEF, 32'h10, 1'b0);
        tick();
        tick();
        Num = 32'd5; Den = 32'd3; Signed = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        drain();
    endtask

    task automatic test_reset_abort();
        start_op(32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        RST = 1'b1;
        tick();
        check_zero_outputs("reset_abort");
        RST = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        run_op(32'd1000, 32'd3, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] n, d;
        logic         s;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            n = $urandom;
            case ($urandom_range(0, 4))
                0: d = 32'd1;
                1: begin n = '0; d = $urandom | 32'd1; end
                2: begin n = 32'($urandom_range(0, 50)); d = 32'($urandom_range(51, 500)); end
                3: d = 32'($urandom_range(1, 255));
                default: d = $urandom | 32'd1;
            endcase
            run_op(n, d, s);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) rd_idx[k] = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
